// File: rtl/alu_pkg.sv
// Shared ALU definitions: subtractor FSM states and default width.
// Imported by the serial subtractor datapath files.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, gate level.
// Mirror of the full-adder cell: d = a - b - b_in, borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic d,
    output logic b_out
);

    logic axb;

    assign axb   = a ^ b;
    assign d     = axb ^ b_in;
    assign b_out = (~a & b) | (~axb & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first.
// One full_subtractor cell plus shift registers, counter and FSM.
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [WIDTH-1:0] diff_nx;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bo;

    full_subtractor u_cell (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .b_in  (brw),
        .d     (cell_d),
        .b_out (cell_bo)
    );

    assign diff_nx = {cell_d, diff_sh[WIDTH-1:1]};

    // FSM, serial datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            diff      <= '0;
            b_out     <= 1'b0;
            ovf       <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            diff_sh   <= '0;
            brw       <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        brw      <= b_in;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    diff_sh <= diff_nx;
                    brw     <= cell_bo;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff      <= diff_nx;
                        b_out     <= cell_bo;
                        ovf       <= (a_msb != b_msb) && (cell_d != a_msb);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: directed corner cases, back-pressure,
// mid-run reset and a random back-to-back sweep, scoreboard checked.
module tb_serial_subtractor;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc = -1;
    bit chk_tput = 0;
    int n_tput_bad = 0;

    exp_t exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic bi);
        exp_t e;
        int   r;
        r    = int'(av) - int'(bv) - int'(bi);
        e.d  = W'(r);
        e.bo = (r < 0);
        e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
        return e;
    endfunction

    // Monitor: compare each consumed result against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {23'd0, diff, b_out}, 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("b_out", 32'(b_out), 32'(e.bo));
                check("ovf", 32'(ovf), 32'(e.ov));
            end
        end
    end

    // Caller is positioned just after a rising edge
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic bi);
        bit acc;
        acc      = 0;
        a        = av;
        b        = bv;
        b_in     = bi;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(model(av, bv, bi));
            if (chk_tput && last_acc >= 0) begin
                n_checks++;
                if (cyc - last_acc != W + 2) begin
                    n_fail++;
                    n_tput_bad++;
                    $display("FAIL throughput: got %0d, expected %0d",
                             cyc - last_acc, W + 2);
                end
            end
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_diff"}, 32'(diff), 32'd0);
        check({tag, "_b_out"}, 32'(b_out), 32'd0);
        check({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        int lat;
        logic [W-1:0] hold_d;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        b_in      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: basic subtract plus latency, counted in sampled cycles
        do_op(8'h05, 8'h03, 1'b0);
        lat = 0;
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'd9);
        drain();

        // 2..4: borrow, overflow and borrow-in corners
        do_op(8'h03, 8'h05, 1'b0);
        drain();
        do_op(8'h80, 8'h01, 1'b0);
        drain();
        do_op(8'h7F, 8'hFF, 1'b0);
        drain();
        do_op(8'h00, 8'h00, 1'b1);
        drain();
        do_op(8'hFF, 8'hFF, 1'b1);
        drain();

        // 5: back-pressure in DONE, stray in_valid must be ignored
        out_ready = 1'b0;
        do_op(8'hA5, 8'h3C, 1'b1);
        for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        hold_d   = diff;
        a        = 8'h11;
        b        = 8'h22;
        b_in     = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_diff", 32'(diff), 32'(hold_d));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // 6: reset in the middle of RUN abandons the operation
        do_op(8'hC3, 8'h5A, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("abort");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(8'h10, 8'h01, 1'b0);
        drain();

        // Random back-to-back sweep with out_ready held high
        chk_tput = 1;
        last_acc = -1;
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)));
        end
        chk_tput = 0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
